wb_slave_intercon: RTL and testbench

Parametrised WISHBONE classic single-master to N-slave interconnect. It replaces the hard-wired two-bit address select and ack/data mux that sits behind the PCI bridge's WISHBONE master port.
- Per-slave base/mask address decode, lowest index has priority.
- Registered strobe and response paths.
- Error response for unmapped addresses.
- Optional bus timeout.
- Saturating error counter for diagnostics.

---
 rtl/wb_slave_intercon.sv | 171 +++++++++++++++++
 tb/tb_wb_slave_intercon.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_intercon.sv
// WISHBONE classic single-master to N-slave interconnect: base/mask decode, registered strobe/response paths.
// Optional bus timeout is compiled in by defining WB_INTERCON_TIMEOUT_EN.
module wb_slave_intercon #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h00100000, 32'h00000080, 32'h00000040, 32'h00000000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK =
    {32'hFFF00000, 32'hFFF000C0, 32'hFFF000C0, 32'hFFF000C0},
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               m_cyc_i,
  input  logic                               m_stb_i,
  input  logic                               m_we_i,
  input  logic [ADDR_WIDTH-1:0]              m_adr_i,
  input  logic [DATA_WIDTH-1:0]              m_dat_i,
  input  logic [DATA_WIDTH/8-1:0]            m_sel_i,
  output logic [DATA_WIDTH-1:0]              m_dat_o,
  output logic                               m_ack_o,
  output logic                               m_err_o,
  output logic                               m_rty_o,
  output logic [NUM_SLAVES-1:0]              s_cyc_o,
  output logic [NUM_SLAVES-1:0]              s_stb_o,
  output logic                               s_we_o,
  output logic [ADDR_WIDTH-1:0]              s_adr_o,
  output logic [DATA_WIDTH-1:0]              s_dat_o,
  output logic [DATA_WIDTH/8-1:0]            s_sel_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]   s_dat_i,
  input  logic [NUM_SLAVES-1:0]              s_ack_i,
  input  logic [NUM_SLAVES-1:0]              s_err_i,
  input  logic [NUM_SLAVES-1:0]              s_rty_i,
  output logic [15:0]                        err_count_o
);

  typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;
  typedef enum logic [1:0] {RSP_ACK, RSP_ERR, RSP_RTY} rsp_t;

  state_t                  state;
  rsp_t                    rsp;
  logic [NUM_SLAVES-1:0]   sel;
  logic [NUM_SLAVES-1:0]   hit;
  logic [DATA_WIDTH-1:0]   sel_dat;
  logic                    sel_ack;
  logic                    sel_err;
  logic                    sel_rty;
  logic                    any_rsp;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_WIDTH < 1 || TIMEOUT_WIDTH > 31 ||
      TIMEOUT_CYCLES > (2 ** TIMEOUT_WIDTH) - 1) begin : g_bad_timeout
    $error("wb_slave_intercon: TIMEOUT_CYCLES out of range for TIMEOUT_WIDTH");
  end

`ifdef WB_INTERCON_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
`endif

  // Address decode: walk from the top so the lowest matching index wins.
  always_comb begin
    hit = '0;
    for (int i = int'(NUM_SLAVES) - 1; i >= 0; i--) begin
      if ((m_adr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
          (SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH] & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  // Only the selected slave's read data and response lines are visible.
  always_comb begin
    sel_dat = '0;
    for (int i = 0; i < int'(NUM_SLAVES); i++) begin
      if (sel[i]) sel_dat = sel_dat | s_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign sel_ack = |(s_ack_i & sel);
  assign sel_err = |(s_err_i & sel);
  assign sel_rty = |(s_rty_i & sel);
  assign any_rsp = sel_ack | sel_err | sel_rty;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      rsp         <= RSP_ACK;
      sel         <= '0;
      m_dat_o     <= '0;
      m_ack_o     <= 1'b0;
      m_err_o     <= 1'b0;
      m_rty_o     <= 1'b0;
      s_cyc_o     <= '0;
      s_stb_o     <= '0;
      s_we_o      <= 1'b0;
      s_adr_o     <= '0;
      s_dat_o     <= '0;
      s_sel_o     <= '0;
      err_count_o <= '0;
`ifdef WB_INTERCON_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          m_ack_o <= 1'b0;
          m_err_o <= 1'b0;
          m_rty_o <= 1'b0;
          if (m_cyc_i && m_stb_i) begin
            s_we_o  <= m_we_i;
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_sel_o <= m_sel_i;
            if (|hit) begin
              sel     <= hit;
              s_cyc_o <= hit;
              s_stb_o <= hit;
`ifdef WB_INTERCON_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
              state   <= ACTIVE;
            end else begin
              rsp     <= RSP_ERR;
              m_dat_o <= '0;
              state   <= RESP;
            end
          end
        end

        ACTIVE: begin
          if (!m_cyc_i) begin
            // Master abort: release the slave silently.
            s_cyc_o <= '0;
            s_stb_o <= '0;
            state   <= IDLE;
          end else if (any_rsp) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            rsp     <= sel_err ? RSP_ERR : (sel_rty ? RSP_RTY : RSP_ACK);
            m_dat_o <= (sel_err || sel_rty || s_we_o) ? '0 : sel_dat;
            state   <= RESP;
          end
`ifdef WB_INTERCON_TIMEOUT_EN
          else if (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
            s_cyc_o <= '0;
            s_stb_o <= '0;
            rsp     <= RSP_ERR;
            m_dat_o <= '0;
            state   <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        RESP: begin
          m_ack_o <= (rsp == RSP_ACK);
          m_err_o <= (rsp == RSP_ERR);
          m_rty_o <= (rsp == RSP_RTY);
          if (rsp == RSP_ERR && err_count_o != 16'hFFFF) err_count_o <= err_count_o + 16'd1;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_intercon.sv
// Directed bench for wb_slave_intercon: scoreboard of expected master responses plus per-step timing checks.
// Build with WB_INTERCON_TIMEOUT_EN defined to exercise the timeout path.
module tb_wb_slave_intercon;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam logic [2:0] R_ACK = 3'b100;
  localparam logic [2:0] R_ERR = 3'b010;
  localparam logic [2:0] R_RTY = 3'b001;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              m_cyc_i, m_stb_i, m_we_i;
  logic [AW-1:0]     m_adr_i;
  logic [DW-1:0]     m_dat_i;
  logic [DW/8-1:0]   m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic              m_ack_o, m_err_o, m_rty_o;
  logic [NS-1:0]     s_cyc_o, s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [NS*DW-1:0]  s_dat_i;
  logic [NS-1:0]     s_ack_i, s_err_i, s_rty_i;
  logic [15:0]       err_count_o;

  typedef struct {
    logic [2:0]  resp;
    logic [31:0] dat;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          n_assert = 0;
  int          n_fail = 0;

  wb_slave_intercon #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(8), .TIMEOUT_WIDTH(8)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_adr_i(m_adr_i),
    .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .m_rty_o(m_rty_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .err_count_o(err_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Scoreboard: every master response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst_i && (m_ack_o || m_err_o || m_rty_o)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_resp", {m_ack_o, m_err_o, m_rty_o}, e.resp);
        chk("sb_dat", m_dat_o, e.dat);
        chk("sb_errcnt", err_count_o, e.cnt);
      end
    end
  end

  // One master transaction; slave < 0 means an unmapped address.
  task automatic do_txn(input string tag, input logic [31:0] adr, input logic we,
                        input logic [31:0] wdat, input int slave, input int waits,
                        input logic [2:0] sresp, input logic [31:0] rdat,
                        input logic [2:0] eresp);
    exp_t e;
    e.resp = eresp;
    e.dat  = (eresp == R_ACK && !we) ? rdat : 32'h0;
    if (eresp == R_ERR) exp_cnt = sat_inc(exp_cnt);
    e.cnt  = exp_cnt;
    exp_q.push_back(e);
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we; m_adr_i = adr; m_dat_i = wdat; m_sel_i = '1;
    @(negedge clk);
    if (slave < 0) begin
      chk({tag, "_no_stb"}, s_stb_o, 0);
    end else begin
      chk({tag, "_stb"}, s_stb_o, 64'(1 << slave));
      chk({tag, "_cyc"}, s_cyc_o, 64'(1 << slave));
      chk({tag, "_adr"}, s_adr_o, adr);
      chk({tag, "_we"}, s_we_o, we);
      chk({tag, "_wdat"}, s_dat_o, wdat);
      for (int i = 0; i < waits; i++) begin
        @(negedge clk);
        chk({tag, "_stb_wait"}, s_stb_o, 64'(1 << slave));
      end
      s_ack_i[slave] = sresp[2];
      s_err_i[slave] = sresp[1];
      s_rty_i[slave] = sresp[0];
      s_dat_i[slave*DW +: DW] = rdat;
      @(negedge clk);
      s_ack_i = '0; s_err_i = '0; s_rty_i = '0; s_dat_i = '0;
      chk({tag, "_stb_drop"}, s_stb_o, 0);
      chk({tag, "_early_resp"}, {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    end
    @(negedge clk);
    chk({tag, "_latency"}, {m_ack_o, m_err_o, m_rty_o}, eresp);
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    @(negedge clk);
    chk({tag, "_pulse_end"}, {m_ack_o, m_err_o, m_rty_o}, 3'b000);
  endtask

  initial begin
    int n_high;
    rst_i = 1'b1;
    m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0;
    s_dat_i = '0; s_ack_i = '0; s_err_i = '0; s_rty_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    chk("rst_dat", m_dat_o, 0);
    chk("rst_errcnt", err_count_o, 0);
    rst_i = 1'b0;
    @(negedge clk);

    do_txn("rd_s0", 32'h00000000, 1'b0, 32'h0, 0, 0, R_ACK, 32'h54495343, R_ACK);
    chk("rd_s0_hold", m_dat_o, 32'h54495343);
    do_txn("wr_s3", 32'h00100010, 1'b1, 32'hA5, 3, 5, R_ACK, 32'h12345678, R_ACK);
    do_txn("err_s2", 32'h00000080, 1'b0, 32'h0, 2, 0, 3'b110, 32'hCAFEF00D, R_ERR);
    do_txn("unmapped", 32'h00200000, 1'b0, 32'h0, -1, 0, 3'b000, 32'h0, R_ERR);
    chk("errcnt_2", err_count_o, 16'd2);
    s_ack_i[0] = 1'b1;
    do_txn("rty_s1", 32'h00000044, 1'b0, 32'h0, 1, 2, 3'b101, 32'h11111111, R_RTY);
    do_txn("rd_s2", 32'h00000088, 1'b0, 32'h0, 2, 1, R_ACK, 32'hDEADBEEF, R_ACK);

    // Reset in the middle of an active slave cycle.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h00100000;
    @(negedge clk);
    chk("mid_stb", s_stb_o, 4'b1000);
    #2 rst_i = 1'b1;
    #1;
    chk("mid_rst_stb", s_stb_o, 0);
    chk("mid_rst_cyc", s_cyc_o, 0);
    chk("mid_rst_dat", m_dat_o, 0);
    chk("mid_rst_errcnt", err_count_o, 0);
    exp_cnt = 16'd0;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_stb", s_stb_o, 0);

`ifdef WB_INTERCON_TIMEOUT_EN
    begin
      exp_t e;
      exp_cnt = sat_inc(exp_cnt);
      e.resp = R_ERR; e.dat = 32'h0; e.cnt = exp_cnt;
      exp_q.push_back(e);
    end
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h00000040;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_stb_high", s_stb_o, 4'b0010);
    end
    @(negedge clk);
    chk("tmo_stb_low", s_stb_o, 0);
    @(negedge clk);
    chk("tmo_err", {m_ack_o, m_err_o, m_rty_o}, R_ERR);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
`else
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h00000040;
    @(negedge clk);
    n_high = 0;
    for (int i = 0; i < 1000; i++) begin
      if (s_stb_o[1]) n_high++;
      @(negedge clk);
    end
    chk("no_tmo_stb_cycles", n_high, 1000);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    chk("no_tmo_abort_stb", s_stb_o, 0);
`endif

    // Abort on the third ACTIVE cycle.
    m_cyc_i = 1'b1; m_stb_i = 1'b1; m_adr_i = 32'h00000040;
    repeat (3) @(negedge clk);
    chk("abort_stb_before", s_stb_o, 4'b0010);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    @(negedge clk);
    chk("abort_stb", s_stb_o, 0);
    chk("abort_cyc", s_cyc_o, 0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_resp", {m_ack_o, m_err_o, m_rty_o}, 3'b000);
    end
    chk("abort_errcnt", err_count_o, exp_cnt);

    // Saturation of the error counter.
    force dut.err_count_o = 16'hFFFF;
    @(negedge clk);
    release dut.err_count_o;
    exp_cnt = 16'hFFFF;
    do_txn("sat_unmapped", 32'h00300000, 1'b0, 32'h0, -1, 0, 3'b000, 32'h0, R_ERR);
    chk("sat_errcnt", err_count_o, 16'hFFFF);

    repeat (2) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
